// File: rtl/pulse_maker_pkg.sv
// pulse_maker_pkg: shared types and helpers for the push-button pulse shaper.
//   rep_state_t - auto-repeat FSM states
//   cnt_width   - bit width of a saturating counter that must hold max_val
package pulse_maker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pulse_maker_debounce.sv
// pulse_maker_debounce: synchronizes a raw asynchronous level and filters bounce.
//   clock - system clock, rising edge
//   reset - asynchronous active-low reset
//   raw   - raw button level, asynchronous to clock
//   level - debounced level; follows sync output after DEBOUNCE_CYCLES equal samples
module pulse_maker_debounce
    import pulse_maker_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_out;

    always_ff @(posedge clock or negedge reset)
        if (!reset)
            sync <= '0;
        else
            sync <= {sync[SYNC_STAGES-2:0], raw};

    assign sync_out = sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign level = sync_out;
        end else begin : g_filter
            localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] cnt;
            logic          lvl;
            // The stored count lags the sample count by one: the sample that
            // would bring it to DEBOUNCE_CYCLES commits the new level instead.
            always_ff @(posedge clock or negedge reset)
                if (!reset) begin
                    cnt <= '0;
                    lvl <= 1'b0;
                end else if (sync_out == lvl) begin
                    cnt <= '0;
                end else if (cnt >= LAST) begin
                    lvl <= sync_out;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            assign level = lvl;
        end
    endgenerate

endmodule

// File: rtl/pulse_maker.sv
// pulse_maker: turns a bouncy asynchronous button level into 1-cycle pulses,
// with optional auto-repeat while the button stays held.
//   clock   - system clock, rising edge
//   reset   - asynchronous active-low reset
//   i_pulse - raw button level, 1 = pressed
//   o_pulse - registered single-cycle pulse per press or repeat
module pulse_maker
    import pulse_maker_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_EN       = 0,
    parameter int HOLD_CYCLES     = 16,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic i_pulse,
    output logic o_pulse
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("pulse_maker: SYNC_STAGES must be at least 2");
        end
        if (REPEAT_EN != 0 && (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2)) begin : g_bad_repeat
            $error("pulse_maker: HOLD_CYCLES and REPEAT_CYCLES must be at least 2");
        end
    endgenerate

    logic level;
    logic level_q;
    logic rise;
    logic fire;

    pulse_maker_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock(clock),
        .reset(reset),
        .raw  (i_pulse),
        .level(level)
    );

    always_ff @(posedge clock or negedge reset)
        if (!reset)
            level_q <= 1'b0;
        else
            level_q <= level;

    assign rise = level & ~level_q;

    generate
        if (REPEAT_EN != 0) begin : g_repeat
            localparam int CMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
            localparam int CW   = cnt_width(CMAX);
            localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
            localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
            rep_state_t    state, state_nx;
            logic [CW-1:0] cnt, cnt_nx;
            always_ff @(posedge clock or negedge reset)
                if (!reset) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    state <= state_nx;
                    cnt   <= cnt_nx;
                end
            // A low filtered level is checked before expiry so a release on
            // the expiry cycle suppresses the repeat pulse.
            always_comb begin
                state_nx = state;
                cnt_nx   = cnt;
                fire     = 1'b0;
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state_nx = HOLD;
                            cnt_nx   = '0;
                        end
                    end
                    HOLD, REPEAT: begin
                        if (!level) begin
                            state_nx = IDLE;
                            cnt_nx   = '0;
                        end else if (cnt >= ((state == HOLD) ? HOLD_LAST : REP_LAST)) begin
                            fire     = 1'b1;
                            state_nx = REPEAT;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + 1'b1;
                        end
                    end
                    default: begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                endcase
            end
        end else begin : g_single
            assign fire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset)
        if (!reset)
            o_pulse <= 1'b0;
        else
            o_pulse <= rise | fire;

endmodule

// File: tb/tb_pulse_maker.sv
// tb_pulse_maker: directed checks of press latency, debounce, reset and auto-repeat.
module tb_pulse_maker;
    import pulse_maker_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic in_a  = 1'b0;
    logic in_r  = 1'b0;
    logic in_b  = 1'b0;
    logic o_a, o_r, o_b;
    logic pa = 1'b0, pr = 1'b0, pb = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   qa[$];
    int   qr[$];
    int   qb[$];
    int   p;

    pulse_maker dut_a (.clock(clock), .reset(reset), .i_pulse(in_a), .o_pulse(o_a));
    pulse_maker #(.REPEAT_EN(1)) dut_r (.clock(clock), .reset(reset), .i_pulse(in_r), .o_pulse(o_r));
    pulse_maker #(.DEBOUNCE_CYCLES(0)) dut_b (.clock(clock), .reset(reset), .i_pulse(in_b), .o_pulse(o_b));

    always #2 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Stamp each output pulse with the count of rising edges seen so far and
    // flag any output that stays high for two samples in a row.
    always @(negedge clock) begin
        if (o_a) begin
            qa.push_back(cyc);
            chk("a_width", 32'(pa), 0);
        end
        if (o_r) begin
            qr.push_back(cyc);
            chk("r_width", 32'(pr), 0);
        end
        if (o_b) begin
            qb.push_back(cyc);
            chk("b_width", 32'(pb), 0);
        end
        pa <= o_a;
        pr <= o_r;
        pb <= o_b;
    end

    initial begin
        int rep_exp[4] = '{7, 23, 31, 39};
        in_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("rst_a", 32'(o_a), 0);
            chk("rst_r", 32'(o_r), 0);
            chk("rst_b", 32'(o_b), 0);
        end
        reset = 1'b1;
        p = cyc;
        cycles(40);
        chk("press_n", qa.size(), 1);
        chk("press_t", (qa.size() > 0) ? qa[0] : -1, p + 7);

        qa.delete();
        in_a = 1'b0;
        cycles(10);
        chk("release_n", qa.size(), 0);
        p = cyc;
        in_a = 1'b1;
        cycles(20);
        chk("repress_n", qa.size(), 1);
        chk("repress_t", (qa.size() > 0) ? qa[0] : -1, p + 7);

        qa.delete();
        in_a = 1'b0;
        cycles(20);
        in_a = 1'b1;
        cycles(3);
        in_a = 1'b0;
        cycles(15);
        chk("glitch3_n", qa.size(), 0);
        p = cyc;
        in_a = 1'b1;
        cycles(5);
        in_a = 1'b0;
        cycles(15);
        chk("glitch5_n", qa.size(), 1);
        chk("glitch5_t", (qa.size() > 0) ? qa[0] : -1, p + 7);

        p = cyc;
        in_a = 1'b1;
        cycles(7);
        chk("pre_async", 32'(o_a), 1);
        reset = 1'b0;
        #1;
        chk("async_o", 32'(o_a), 0);
        chk("async_level", 32'(dut_a.level), 0);
        cycles(2);
        qa.delete();
        reset = 1'b1;
        p = cyc;
        cycles(15);
        chk("held_at_release_n", qa.size(), 1);
        chk("held_at_release_t", (qa.size() > 0) ? qa[0] : -1, p + 7);
        in_a = 1'b0;

        p = cyc;
        in_b = 1'b1;
        cycles(10);
        chk("bypass_n", qb.size(), 1);
        chk("bypass_t", (qb.size() > 0) ? qb[0] : -1, p + 3);
        in_b = 1'b0;
        cycles(10);

        qr.delete();
        p = cyc;
        in_r = 1'b1;
        cycles(40);
        in_r = 1'b0;
        cycles(20);
        chk("rep_n", qr.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rep_t%0d", i), (qr.size() > i) ? qr[i] : -1, p + rep_exp[i]);

        qr.delete();
        p = cyc;
        in_r = 1'b1;
        cycles(16);
        in_r = 1'b0;
        cycles(20);
        chk("expiry_release_n", qr.size(), 1);
        chk("expiry_release_t", (qr.size() > 0) ? qr[0] : -1, p + 7);
        chk("expiry_release_idle", 32'(dut_r.g_repeat.state), 32'(IDLE));

        qr.delete();
        p = cyc;
        in_r = 1'b1;
        cycles(17);
        in_r = 1'b0;
        cycles(20);
        chk("late_release_n", qr.size(), 2);
        chk("late_release_t", (qr.size() > 1) ? qr[1] : -1, p + 23);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
